tick_timer_cmp: RTL and testbench

Programmable compare/interrupt timer that sits directly downstream of the free-running hardware tick counter. It consumes the 32-bit tick count (one increment per 10001 system clocks) and lets the CPU arm a one-shot or periodic interval. On expiry it raises a level interrupt. The CPU accesses it through a simple single-cycle register bus.

---
 rtl/tick_timer_cmp_pkg.sv | 30 +++
 rtl/tick_timer_cmp_if.sv | 40 ++++
 rtl/tick_timer_cmp.sv | 203 ++++++++++++++++++++
 tb/tb_tick_timer_cmp.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_timer_cmp_pkg.sv
// -----------------------------------------------------------------------------
// t03_timer_pkg
// Shared definitions for the tick compare/interrupt timer:
//   - register address map (CTRL, INTERVAL, STATUS, NOW)
//   - bit positions inside CTRL and STATUS
//   - compare FSM state encoding
// No ports; imported by the timer module and its testbench.
// -----------------------------------------------------------------------------
package t03_timer_pkg;

  // Register map on the 2-bit bus address
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_INTERVAL = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_NOW      = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;

  // STATUS bit positions
  localparam int STATUS_PENDING_BIT = 0;

  // Compare FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } timer_state_t;

endpackage

// File: rtl/tick_timer_cmp_if.sv
// -----------------------------------------------------------------------------
// tick_timer_cmp_if
// Single-cycle CPU register bus used to access the tick compare timer.
//   req   : request pulse, one cycle per access (master -> slave)
//   we    : 1 = write, 0 = read, qualified by req (master -> slave)
//   addr  : register select (master -> slave)
//   wdata : write data (master -> slave)
//   rdata : read data, non-zero only while ack is high (slave -> master)
//   ack   : one-cycle acknowledge, one cycle after req (slave -> master)
// -----------------------------------------------------------------------------
interface tick_timer_cmp_if #(
  parameter int CNT_W = 32
) ();

  logic             req;
  logic             we;
  logic [1:0]       addr;
  logic [CNT_W-1:0] wdata;
  logic [CNT_W-1:0] rdata;
  logic             ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );

endinterface

// File: rtl/tick_timer_cmp.sv
// -----------------------------------------------------------------------------
// tick_timer_cmp
// Programmable compare/interrupt timer driven by the free-running hardware
// tick count. The CPU arms a one-shot or periodic interval; on expiry a
// sticky pending flag is set and presented as a level interrupt.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   tick_count : free-running tick value, wraps at 2^CNT_W
//   bus        : register bus, slave side (req/we/addr/wdata -> rdata/ack)
//   irq        : level interrupt, equal to STATUS.pending
// -----------------------------------------------------------------------------
module tick_timer_cmp
  import t03_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] tick_count,
  tick_timer_cmp_if.slave  bus,
  output logic             irq
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  timer_state_t     r_state;
  logic             r_en;
  logic             r_periodic;
  logic [CNT_W-1:0] r_interval;
  logic [CNT_W-1:0] r_base;
  logic             r_pending;
  logic             r_ack;
  logic [CNT_W-1:0] r_rdata;

  timer_state_t     w_state_next;
  logic             w_en_next;
  logic [CNT_W-1:0] w_base_next;
  logic             w_pending_next;
  logic [CNT_W-1:0] w_rdata;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_interval;
  logic w_wr_status;

  assign w_wr          = bus.req & bus.we;
  assign w_wr_ctrl     = w_wr && (bus.addr == ADDR_CTRL);
  assign w_wr_interval = w_wr && (bus.addr == ADDR_INTERVAL);
  assign w_wr_status   = w_wr && (bus.addr == ADDR_STATUS);

  // ---------------------------------------------------------------------------
  // Compare
  // Elapsed is taken modulo 2^CNT_W so a wrap of tick_count between arming
  // and expiry does not cause an early or missed fire.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] w_elapsed;
  logic             w_expire;

  assign w_elapsed = tick_count - r_base;
  assign w_expire  = (r_state == ARMED) && (w_elapsed >= r_interval);

  // ---------------------------------------------------------------------------
  // Compare FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_en_next      = r_en;
    w_base_next    = r_base;
    w_pending_next = r_pending;

    case (r_state)
      IDLE: begin
        w_state_next = IDLE;
      end
      ARMED: begin
        if (w_expire) begin
          // A zero interval in periodic mode would re-fire every cycle, so it
          // is treated like one-shot.
          if (r_periodic && (r_interval != '0)) begin
            // Advance from the previous base rather than tick_count so the
            // period does not drift with evaluation latency.
            w_base_next = r_base + r_interval;
          end else begin
            w_en_next    = 1'b0;
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_en_next    = 1'b0;
      end
    endcase

    // A CTRL write overrides whatever the compare decided for state/base/en.
    if (w_wr_ctrl) begin
      if (bus.wdata[CTRL_EN_BIT]) begin
        w_state_next = ARMED;
        w_en_next    = 1'b1;
        w_base_next  = tick_count;
      end else begin
        w_state_next = IDLE;
        w_en_next    = 1'b0;
      end
    end

    // W1C first, expiry second: a simultaneous set wins.
    if (w_wr_status && bus.wdata[STATUS_PENDING_BIT]) begin
      w_pending_next = 1'b0;
    end
    if (w_expire) begin
      w_pending_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_en      <= 1'b0;
      r_base    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_en      <= w_en_next;
      r_base    <= w_base_next;
      r_pending <= w_pending_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: plain R/W configuration fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_periodic <= 1'b0;
      r_interval <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_periodic <= bus.wdata[CTRL_PERIODIC_BIT];
      end
      // Takes effect for the compare from the next cycle; base is untouched.
      if (w_wr_interval) begin
        r_interval <= bus.wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (values as they stand at the req edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (bus.addr)
      ADDR_CTRL: begin
        w_rdata[CTRL_EN_BIT]       = r_en;
        w_rdata[CTRL_PERIODIC_BIT] = r_periodic;
      end
      ADDR_INTERVAL: begin
        w_rdata = r_interval;
      end
      ADDR_STATUS: begin
        w_rdata[STATUS_PENDING_BIT] = r_pending;
      end
      ADDR_NOW: begin
        w_rdata = tick_count;
      end
      default: begin
        w_rdata = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus response: ack one cycle after every req; rdata only alongside a read ack
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= bus.req;
      if (bus.req && !bus.we) begin
        r_rdata <= w_rdata;
      end else begin
        r_rdata <= '0;
      end
    end
  end

  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;
  assign irq       = r_pending;

endmodule

// File: tb/tb_tick_timer_cmp.sv
// -----------------------------------------------------------------------------
// tb_tick_timer_cmp
// Directed self-checking bench for tick_timer_cmp. The tick count is driven
// directly so expiry points can be placed on exact cycles. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tick_timer_cmp;
  import t03_timer_pkg::*;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] tick;
  logic             irq;

  int n_checks;
  int n_fail;

  tick_timer_cmp_if #(.CNT_W(CNT_W)) bus_if ();

  tick_timer_cmp #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_count (tick),
    .bus        (bus_if.slave),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bus helpers (stimulus only)
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [1:0] a, input logic [CNT_W-1:0] d);
    @(negedge clk);
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.wdata = '0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [CNT_W-1:0] d,
                         output logic ackv);
    @(negedge clk);
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    @(negedge clk);
    bus_if.req  = 1'b0;
    d    = bus_if.rdata;
    ackv = bus_if.ack;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Power-on reset values
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [CNT_W-1:0] d;
    logic             a;
    if (irq !== 1'b0) begin $display("FAIL reset_irq got=%0b exp=0", irq); n_fail++; end
    n_checks++;
    if (bus_if.ack !== 1'b0) begin $display("FAIL reset_ack got=%0b exp=0", bus_if.ack); n_fail++; end
    n_checks++;
    if (bus_if.rdata !== '0) begin $display("FAIL reset_rdata got=%h exp=0", bus_if.rdata); n_fail++; end
    n_checks++;
    @(negedge clk);
    rst  = 1'b0;
    tick = 32'd7;
    do_read(ADDR_CTRL, d, a);
    if (d !== '0 || a !== 1'b1) begin $display("FAIL reset_ctrl got=%h ack=%0b exp=0 ack=1", d, a); n_fail++; end
    n_checks++;
    do_read(ADDR_INTERVAL, d, a);
    if (d !== '0) begin $display("FAIL reset_interval got=%h exp=0", d); n_fail++; end
    n_checks++;
    do_read(ADDR_STATUS, d, a);
    if (d !== '0) begin $display("FAIL reset_status got=%h exp=0", d); n_fail++; end
    n_checks++;
    do_read(ADDR_NOW, d, a);
    if (d !== 32'd7) begin $display("FAIL reset_now got=%h exp=7", d); n_fail++; end
    n_checks++;
    $display("test_reset done");
  endtask

  // ---------------------------------------------------------------------------
  // One-shot: INTERVAL=5 armed at tick 100 fires after tick 105
  // ---------------------------------------------------------------------------
  task automatic test_one_shot();
    logic [CNT_W-1:0] d;
    logic             a;
    apply_reset();
    tick = 32'd100;
    do_write(ADDR_INTERVAL, 32'd5);
    do_write(ADDR_CTRL, 32'h1);
    for (int t = 101; t <= 105; t++) begin
      @(negedge clk);
      if (irq !== 1'b0) begin $display("FAIL oneshot_early tick=%0d got=%0b exp=0", tick, irq); n_fail++; end
      n_checks++;
      tick = CNT_W'(t);
    end
    @(negedge clk);
    if (irq !== 1'b1) begin $display("FAIL oneshot_fire got=%0b exp=1", irq); n_fail++; end
    n_checks++;
    do_read(ADDR_CTRL, d, a);
    if (d !== 32'h0) begin $display("FAIL oneshot_ctrl got=%h exp=0", d); n_fail++; end
    n_checks++;
    if (irq !== 1'b1) begin $display("FAIL oneshot_hold got=%0b exp=1", irq); n_fail++; end
    n_checks++;
    do_write(ADDR_STATUS, 32'h1);
    if (irq !== 1'b0) begin $display("FAIL oneshot_clear got=%0b exp=0", irq); n_fail++; end
    n_checks++;
    for (int t = 106; t <= 115; t++) begin
      @(negedge clk);
      tick = CNT_W'(t);
    end
    @(negedge clk);
    if (irq !== 1'b0) begin $display("FAIL oneshot_idle got=%0b exp=0", irq); n_fail++; end
    n_checks++;
    $display("test_one_shot done");
  endtask

  // ---------------------------------------------------------------------------
  // Periodic: INTERVAL=3 armed at tick 10 fires after 13, 16, 19
  // ---------------------------------------------------------------------------
  task automatic test_periodic();
    logic [CNT_W-1:0] d;
    logic             a;
    apply_reset();
    tick = 32'd10;
    do_write(ADDR_INTERVAL, 32'd3);
    do_write(ADDR_CTRL, 32'h3);
    for (int k = 0; k < 3; k++) begin
      for (int j = 1; j <= 3; j++) begin
        @(negedge clk);
        if (irq !== 1'b0) begin $display("FAIL periodic_early tick=%0d got=%0b exp=0", tick, irq); n_fail++; end
        n_checks++;
        tick = CNT_W'(10 + 3 * k + j);
      end
      @(negedge clk);
      if (irq !== 1'b1) begin $display("FAIL periodic_fire tick=%0d got=%0b exp=1", tick, irq); n_fail++; end
      n_checks++;
      do_write(ADDR_STATUS, 32'h1);
      if (irq !== 1'b0) begin $display("FAIL periodic_clear tick=%0d got=%0b exp=0", tick, irq); n_fail++; end
      n_checks++;
    end
    do_read(ADDR_CTRL, d, a);
    if (d !== 32'h3) begin $display("FAIL periodic_ctrl got=%h exp=3", d); n_fail++; end
    n_checks++;
    $display("test_periodic done");
  endtask

  // ---------------------------------------------------------------------------
  // Wrap-around: arm at 0xFFFF_FFFE with INTERVAL=4 -> fires after tick 2
  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    logic [CNT_W-1:0] tv;
    apply_reset();
    tick = 32'hFFFF_FFFE;
    do_write(ADDR_INTERVAL, 32'd4);
    do_write(ADDR_CTRL, 32'h1);
    tv = tick;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (irq !== 1'b0) begin $display("FAIL wrap_early tick=%h got=%0b exp=0", tick, irq); n_fail++; end
      n_checks++;
      tv   = tv + 1;
      tick = tv;
    end
    @(negedge clk);
    if (irq !== 1'b1) begin $display("FAIL wrap_fire tick=%h got=%0b exp=1", tick, irq); n_fail++; end
    n_checks++;
    $display("test_wrap done");
  endtask

  // ---------------------------------------------------------------------------
  // Race: STATUS W1C on the same edge as an expiry keeps pending set
  // ---------------------------------------------------------------------------
  task automatic test_race();
    apply_reset();
    tick = 32'd50;
    do_write(ADDR_INTERVAL, 32'd2);
    do_write(ADDR_CTRL, 32'h3);
    for (int t = 51; t <= 52; t++) begin
      @(negedge clk);
      tick = CNT_W'(t);
    end
    @(negedge clk);
    if (irq !== 1'b1) begin $display("FAIL race_first got=%0b exp=1", irq); n_fail++; end
    n_checks++;
    tick = 32'd53;
    @(negedge clk);
    // expiry at 54 and W1C land on the same edge
    tick         = 32'd54;
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = ADDR_STATUS;
    bus_if.wdata = 32'h1;
    @(negedge clk);
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.wdata = '0;
    if (bus_if.ack !== 1'b1) begin $display("FAIL race_ack got=%0b exp=1", bus_if.ack); n_fail++; end
    n_checks++;
    if (irq !== 1'b1) begin $display("FAIL race_irq got=%0b exp=1", irq); n_fail++; end
    n_checks++;
    @(negedge clk);
    if (irq !== 1'b1) begin $display("FAIL race_hold got=%0b exp=1", irq); n_fail++; end
    n_checks++;
    do_write(ADDR_STATUS, 32'h1);
    if (irq !== 1'b0) begin $display("FAIL race_clear got=%0b exp=0", irq); n_fail++; end
    n_checks++;
    $display("test_race done");
  endtask

  // ---------------------------------------------------------------------------
  // INTERVAL=0 in periodic mode fires once and disarms
  // ---------------------------------------------------------------------------
  task automatic test_interval_zero();
    logic [CNT_W-1:0] d;
    logic             a;
    apply_reset();
    tick = 32'd200;
    do_write(ADDR_INTERVAL, 32'd0);
    do_write(ADDR_CTRL, 32'h3);
    if (irq !== 1'b0) begin $display("FAIL izero_pre got=%0b exp=0", irq); n_fail++; end
    n_checks++;
    @(negedge clk);
    if (irq !== 1'b1) begin $display("FAIL izero_fire got=%0b exp=1", irq); n_fail++; end
    n_checks++;
    do_read(ADDR_CTRL, d, a);
    if (d !== 32'h2) begin $display("FAIL izero_ctrl got=%h exp=2", d); n_fail++; end
    n_checks++;
    do_write(ADDR_STATUS, 32'h1);
    if (irq !== 1'b0) begin $display("FAIL izero_clear got=%0b exp=0", irq); n_fail++; end
    n_checks++;
    for (int t = 201; t <= 205; t++) begin
      @(negedge clk);
      tick = CNT_W'(t);
    end
    @(negedge clk);
    if (irq !== 1'b0) begin $display("FAIL izero_idle got=%0b exp=0", irq); n_fail++; end
    n_checks++;
    $display("test_interval_zero done");
  endtask

  // ---------------------------------------------------------------------------
  // Back-to-back reads on four consecutive cycles
  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [CNT_W-1:0] exp_d [4];
    apply_reset();
    tick = 32'h0000_0ABC;
    do_write(ADDR_INTERVAL, 32'h1234_5678);
    do_write(ADDR_CTRL, 32'h2);
    exp_d[0] = 32'h2;
    exp_d[1] = 32'h1234_5678;
    exp_d[2] = 32'h0;
    exp_d[3] = 32'h0000_0ABC;
    @(negedge clk);
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.ack !== 1'b1 || bus_if.rdata !== exp_d[i]) begin
        $display("FAIL b2b_read%0d got ack=%0b data=%h exp ack=1 data=%h", i, bus_if.ack, bus_if.rdata, exp_d[i]);
        n_fail++;
      end
      n_checks++;
      if (i < 3) bus_if.addr = 2'(i + 1);
      else       bus_if.req  = 1'b0;
    end
    @(negedge clk);
    if (bus_if.ack !== 1'b0 || bus_if.rdata !== '0) begin
      $display("FAIL b2b_idle got ack=%0b data=%h exp ack=0 data=0", bus_if.ack, bus_if.rdata);
      n_fail++;
    end
    n_checks++;
    $display("test_back_to_back done");
  endtask

  // ---------------------------------------------------------------------------
  // Reset while armed with pending set and an ack in flight
  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [CNT_W-1:0] d;
    logic             a;
    apply_reset();
    tick = 32'd300;
    do_write(ADDR_INTERVAL, 32'd1);
    do_write(ADDR_CTRL, 32'h3);
    @(negedge clk);
    tick = 32'd301;
    @(negedge clk);
    if (irq !== 1'b1) begin $display("FAIL rstmid_pending got=%0b exp=1", irq); n_fail++; end
    n_checks++;
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = ADDR_NOW;
    @(posedge clk);
    #2;
    if (bus_if.ack !== 1'b1) begin $display("FAIL rstmid_ack_pre got=%0b exp=1", bus_if.ack); n_fail++; end
    n_checks++;
    rst = 1'b1;
    #1;
    if (irq !== 1'b0 || bus_if.ack !== 1'b0 || bus_if.rdata !== '0) begin
      $display("FAIL rstmid_async got irq=%0b ack=%0b rdata=%h exp 0/0/0", irq, bus_if.ack, bus_if.rdata);
      n_fail++;
    end
    n_checks++;
    bus_if.req = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    tick = 32'd305;
    do_read(ADDR_CTRL, d, a);
    if (d !== '0) begin $display("FAIL rstmid_ctrl got=%h exp=0", d); n_fail++; end
    n_checks++;
    do_read(ADDR_NOW, d, a);
    if (d !== 32'd305 || a !== 1'b1) begin $display("FAIL rstmid_now got=%h ack=%0b exp=305 ack=1", d, a); n_fail++; end
    n_checks++;
    tick = 32'd400;
    repeat (3) @(negedge clk);
    if (irq !== 1'b0) begin $display("FAIL rstmid_idle got=%0b exp=0", irq); n_fail++; end
    n_checks++;
    $display("test_reset_mid done");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    tick         = '0;
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    repeat (3) @(negedge clk);

    test_reset();
    test_one_shot();
    test_periodic();
    test_wrap();
    test_race();
    test_interval_zero();
    test_back_to_back();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
